// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO write-side bundle for the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         req_ready;
    logic                    full;
    logic                    wr_en;
    logic [WIDTH-1:0]        wdata;
    logic [$clog2(NREQ)-1:0] grant_id;
    logic                    busy;

    // Arbiter side: consumes requests and the full flag, drives the FIFO write port
    modport master (
        input  req_valid,
        input  req_data,
        input  full,
        output req_ready,
        output wr_en,
        output wdata,
        output grant_id,
        output busy
    );

    // Environment side: requesters and FIFO
    modport slave (
        output req_valid,
        output req_data,
        output full,
        input  req_ready,
        input  wr_en,
        input  wdata,
        input  grant_id,
        input  busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for N writers into one sync FIFO
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_arbiter_if.master     bus
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST);
    localparam logic [GW-1:0] LAST_IDX  = GW'(NREQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state, state_n;
    logic [GW-1:0]  grant_id, grant_id_n;
    logic [GW-1:0]  last_grant, last_grant_n;
    logic [BW-1:0]  beat_cnt, beat_cnt_n;

    logic [GW-1:0]  rr_sel;
    logic           rr_found;
    logic [GW-1:0]  cand;
    logic           transfer;

    // Round-robin pick: first valid requester after the last grantee, wrapping
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NREQ);
            if (!rr_found && bus.req_valid[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    // A beat moves only when the grantee offers data and the FIFO has room
    assign transfer = (state == GRANT) && bus.req_valid[grant_id] && !bus.full;

    // Zero-latency write path; everything is quiet outside a transfer
    always_comb begin
        bus.wr_en     = 1'b0;
        bus.req_ready = '0;
        bus.wdata     = '0;
        bus.grant_id  = grant_id;
        bus.busy      = (state == GRANT);
        if (transfer) begin
            bus.wr_en     = 1'b1;
            bus.req_ready = NREQ'(1) << grant_id;
            bus.wdata     = bus.req_data[int'(grant_id) * WIDTH +: WIDTH];
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT
    always_comb begin
        state_n      = state;
        grant_id_n   = grant_id;
        last_grant_n = last_grant;
        beat_cnt_n   = beat_cnt;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    state_n    = GRANT;
                    grant_id_n = rr_sel;
                    beat_cnt_n = '0;
                end
            end
            GRANT: begin
                if (!bus.req_valid[grant_id]) begin
                    // Grantee withdrew (possibly before any beat): give up the slot
                    state_n      = IDLE;
                    last_grant_n = grant_id;
                    grant_id_n   = '0;
                end else if (transfer) begin
                    beat_cnt_n = beat_cnt + BW'(1);
                    if (beat_cnt + BW'(1) == LAST_BEAT) begin
                        state_n      = IDLE;
                        last_grant_n = grant_id;
                        grant_id_n   = '0;
                    end
                end
                // full with valid grantee: hold everything, no timeout
            end
            default: begin
                state_n    = IDLE;
                grant_id_n = '0;
            end
        endcase
    end

    // State registers; reset leaves requester 0 with first priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= LAST_IDX;
            beat_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant_id   <= grant_id_n;
            last_grant <= last_grant_n;
            beat_cnt   <= beat_cnt_n;
        end
    end
endmodule
